// File: rtl/sram_pkg.sv
// Shared types and elaboration helpers for the multi-port register-file RAM.
// Latency: none (package only).
// Backpressure: none (package only).
//
// Contents: state encoding of the clear engine, a constant clog2 helper and
// the legality rule tying SRAM_INDEX to SRAM_DEPTH.
package sram_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } sram_state_t;

   // Constant-foldable ceil(log2(value)); clog2(1) == 0.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) begin
            r = i + 1;
         end
      end
      return r;
   endfunction

   // A one-entry array still needs a one-bit address, hence the floor of 1.
   function automatic bit index_ok(input int depth, input int index);
      int need;
      need = (clog2(depth) < 1) ? 1 : clog2(depth);
      return (depth >= 1) && (index == need);
   endfunction

endpackage

// File: rtl/sram_clear_fsm.sv
// Clear engine: walks the array once after reset or on request, writing one entry per cycle.
// Latency: a pass occupies exactly SRAM_DEPTH cycles; o_done pulses in the first IDLE cycle.
// Backpressure: o_ready low (o_busy high) for the whole pass; user writes must wait for o_ready.
//
// Ports:
//   clk, reset      clock (rising edge) and asynchronous active-low reset
//   i_clear         request a new pass (sampled in IDLE only)
//   o_busy/o_ready  pass in progress / user writes accepted (complementary)
//   o_done          one-cycle pulse when a pass has completed
//   o_clr_we        array write strobe from the engine
//   o_clr_addr      array entry written by the engine this cycle
module sram_clear_fsm
   import sram_pkg::*;
#(
   parameter int SRAM_DEPTH = 32,
   parameter int SRAM_INDEX = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_clear,
   output logic                  o_busy,
   output logic                  o_ready,
   output logic                  o_done,
   output logic                  o_clr_we,
   output logic [SRAM_INDEX-1:0] o_clr_addr
);

   localparam logic [SRAM_INDEX-1:0] LAST_PTR = SRAM_INDEX'(SRAM_DEPTH - 1);

   sram_state_t           r_state;
   sram_state_t           w_state_nxt;
   logic [SRAM_INDEX-1:0] r_ptr;
   logic [SRAM_INDEX-1:0] w_ptr_nxt;
   logic                  r_done;
   logic                  w_done_nxt;

   // State register. Reset restarts the pass from entry 0 and kills any
   // pending done pulse; the array itself is deliberately left untouched.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= CLEAR;
         r_ptr   <= '0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_ptr   <= w_ptr_nxt;
         r_done  <= w_done_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      w_done_nxt  = 1'b0;
      case (r_state)
         CLEAR: begin
            if (r_ptr == LAST_PTR) begin
               // Last entry is written on this edge; done is registered so it
               // lines up with the first IDLE cycle.
               w_state_nxt = IDLE;
               w_ptr_nxt   = '0;
               w_done_nxt  = 1'b1;
            end else begin
               w_ptr_nxt = r_ptr + 1'b1;
            end
         end
         IDLE: begin
            if (i_clear) begin
               w_state_nxt = CLEAR;
               w_ptr_nxt   = '0;
            end
         end
         default: begin
            w_state_nxt = CLEAR;
            w_ptr_nxt   = '0;
         end
      endcase
   end

   // Outputs.
   always_comb begin
      o_busy     = (r_state == CLEAR);
      o_ready    = (r_state == IDLE);
      o_done     = r_done;
      o_clr_we   = (r_state == CLEAR);
      o_clr_addr = r_ptr;
   end

endmodule

// File: rtl/sram_nrnw_clr.sv
// Multi-port register-file RAM: NUM_RD async read ports, NUM_WR sync write ports, built-in clear engine.
// Latency: reads combinational; write-to-read 1 cycle (0 cycles with SRAM_BYPASS_EN); clear pass SRAM_DEPTH cycles.
// Backpressure: user writes are dropped while busy_o is high; writers must wait for ready_o.
//
// Optional feature: define SRAM_BYPASS_EN to forward same-cycle write data to matching reads in IDLE.
//
// Ports:
//   clk, reset      clock (rising edge) and asynchronous active-low reset
//   addr_rd_i       packed read addresses, port k at [k*SRAM_INDEX +: SRAM_INDEX]
//   data_rd_o       packed read data, port k at [k*SRAM_WIDTH +: SRAM_WIDTH]
//   addr_wr_i       packed write addresses
//   we_i            per-port write enable
//   data_wr_i       packed write data
//   clear_i         request a clear pass
//   ready_o/busy_o  user writes accepted / clear pass in progress
//   done_o          one-cycle pulse at the end of a clear pass
//   wr_conflict_o   registered: two or more enabled in-range writes hit one address last cycle
module sram_nrnw_clr
   import sram_pkg::*;
#(
   parameter int                    NUM_RD      = 4,
   parameter int                    NUM_WR      = 3,
   parameter int                    SRAM_DEPTH  = 32,
   parameter int                    SRAM_INDEX  = 5,
   parameter int                    SRAM_WIDTH  = 32,
   parameter logic [SRAM_WIDTH-1:0] CLEAR_VALUE = '0
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NUM_RD*SRAM_INDEX-1:0] addr_rd_i,
   output logic [NUM_RD*SRAM_WIDTH-1:0] data_rd_o,
   input  logic [NUM_WR*SRAM_INDEX-1:0] addr_wr_i,
   input  logic [NUM_WR-1:0]            we_i,
   input  logic [NUM_WR*SRAM_WIDTH-1:0] data_wr_i,
   input  logic                         clear_i,
   output logic                         ready_o,
   output logic                         busy_o,
   output logic                         done_o,
   output logic                         wr_conflict_o
);

   if (!index_ok(SRAM_DEPTH, SRAM_INDEX)) begin : g_bad_index
      $error("sram_nrnw_clr: SRAM_INDEX must equal ceil(log2(SRAM_DEPTH))");
   end
   if (NUM_RD < 1 || NUM_WR < 1) begin : g_bad_ports
      $error("sram_nrnw_clr: NUM_RD and NUM_WR must be at least 1");
   end

   // One extra bit so SRAM_DEPTH itself is representable for the range test.
   localparam logic [SRAM_INDEX:0] DEPTH_W = (SRAM_INDEX + 1)'(SRAM_DEPTH);

   logic [SRAM_WIDTH-1:0] r_mem [SRAM_DEPTH];
   logic                  r_wr_conflict;

   logic                  w_ready;
   logic                  w_clr_we;
   logic [SRAM_INDEX-1:0] w_clr_addr;
   logic                  w_conflict;

   logic [SRAM_INDEX-1:0] w_wr_addr [NUM_WR];
   logic [SRAM_WIDTH-1:0] w_wr_data [NUM_WR];
   logic                  w_wr_inr  [NUM_WR];
   logic [SRAM_INDEX-1:0] w_rd_addr [NUM_RD];
   logic                  w_rd_inr  [NUM_RD];
   logic [SRAM_WIDTH-1:0] w_rd_dat  [NUM_RD];

   sram_clear_fsm #(
      .SRAM_DEPTH (SRAM_DEPTH),
      .SRAM_INDEX (SRAM_INDEX)
   ) u_clear_fsm (
      .clk        (clk),
      .reset      (reset),
      .i_clear    (clear_i),
      .o_busy     (busy_o),
      .o_ready    (w_ready),
      .o_done     (done_o),
      .o_clr_we   (w_clr_we),
      .o_clr_addr (w_clr_addr)
   );

   assign ready_o       = w_ready;
   assign wr_conflict_o = r_wr_conflict;

   // Unpack the flat buses and qualify each address against the array depth.
   for (genvar k = 0; k < NUM_WR; k++) begin : g_wr_unpack
      assign w_wr_addr[k] = addr_wr_i[k*SRAM_INDEX +: SRAM_INDEX];
      assign w_wr_data[k] = data_wr_i[k*SRAM_WIDTH +: SRAM_WIDTH];
      assign w_wr_inr[k]  = ({1'b0, w_wr_addr[k]} < DEPTH_W);
   end

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd_unpack
      assign w_rd_addr[k] = addr_rd_i[k*SRAM_INDEX +: SRAM_INDEX];
      assign w_rd_inr[k]  = ({1'b0, w_rd_addr[k]} < DEPTH_W);
      assign data_rd_o[k*SRAM_WIDTH +: SRAM_WIDTH] = w_rd_dat[k];
   end

   // Array write. The engine owns the array during a pass. Otherwise ports are
   // visited in ascending order so the last nonblocking update to an entry,
   // i.e. the highest-index port, is the one that sticks.
   always_ff @(posedge clk) begin
      if (w_clr_we) begin
         r_mem[w_clr_addr] <= CLEAR_VALUE;
      end else begin
         for (int k = 0; k < NUM_WR; k++) begin
            if (we_i[k] && w_wr_inr[k]) begin
               r_mem[w_wr_addr[k]] <= w_wr_data[k];
            end
         end
      end
   end

   // Any pair of enabled, in-range ports sharing an address.
   always_comb begin
      w_conflict = 1'b0;
      for (int j = 0; j < NUM_WR; j++) begin
         for (int k = j + 1; k < NUM_WR; k++) begin
            if (we_i[j] && we_i[k] && w_wr_inr[j] && w_wr_inr[k] &&
                (w_wr_addr[j] == w_wr_addr[k])) begin
               w_conflict = 1'b1;
            end
         end
      end
   end

   // Writes during a pass are discarded, so they cannot conflict either.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_conflict <= 1'b0;
      end else begin
         r_wr_conflict <= w_ready & w_conflict;
      end
   end

   // Read muxes. Out-of-range addresses return zero rather than indexing past
   // the array.
   always_comb begin
      for (int k = 0; k < NUM_RD; k++) begin
         w_rd_dat[k] = w_rd_inr[k] ? r_mem[w_rd_addr[k]] : '0;
`ifdef SRAM_BYPASS_EN
         // Ascending scan so the highest-index matching port wins, the same
         // port whose data the array will hold after the edge.
         if (w_ready && w_rd_inr[k]) begin
            for (int j = 0; j < NUM_WR; j++) begin
               if (we_i[j] && w_wr_inr[j] && (w_wr_addr[j] == w_rd_addr[k])) begin
                  w_rd_dat[k] = w_wr_data[j];
               end
            end
         end
`endif
      end
   end

endmodule

// File: tb/tb_sram_nrnw_clr.sv
// Directed bench for sram_nrnw_clr: a default-size instance plus a 20-entry instance.
// Latency: checks sample 1 time unit after the rising edge (or after a settle delay for reads).
// Backpressure: user writes are only issued once ready is seen, except the deliberate mid-pass write.
module tb_sram_nrnw_clr;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   // Default instance: 4 read, 3 write, 32 x 32.
   logic [19:0]  addr_rd = '0;
   logic [127:0] data_rd;
   logic [14:0]  addr_wr = '0;
   logic [2:0]   we = '0;
   logic [95:0]  data_wr = '0;
   logic         clear = 1'b0;
   logic         ready, busy, done, conf;

   // Non-power-of-two instance: 2 read, 2 write, 20 x 32.
   logic [9:0]   a20_rd = '0;
   logic [63:0]  d20_rd;
   logic [9:0]   a20_wr = '0;
   logic [1:0]   we20 = '0;
   logic [63:0]  d20_wr = '0;
   logic         clr20 = 1'b0;
   logic         ready20, busy20, done20, conf20;

   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;
   int cnt;
   bit early;

   sram_nrnw_clr dut (
      .clk           (clk),
      .reset         (reset),
      .addr_rd_i     (addr_rd),
      .data_rd_o     (data_rd),
      .addr_wr_i     (addr_wr),
      .we_i          (we),
      .data_wr_i     (data_wr),
      .clear_i       (clear),
      .ready_o       (ready),
      .busy_o        (busy),
      .done_o        (done),
      .wr_conflict_o (conf)
   );

   sram_nrnw_clr #(
      .NUM_RD     (2),
      .NUM_WR     (2),
      .SRAM_DEPTH (20),
      .SRAM_INDEX (5),
      .SRAM_WIDTH (32)
   ) dut20 (
      .clk           (clk),
      .reset         (reset),
      .addr_rd_i     (a20_rd),
      .data_rd_o     (d20_rd),
      .addr_wr_i     (a20_wr),
      .we_i          (we20),
      .data_wr_i     (d20_wr),
      .clear_i       (clr20),
      .ready_o       (ready20),
      .busy_o        (busy20),
      .done_o        (done20),
      .wr_conflict_o (conf20)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_rd(input int k, input int a);
      addr_rd[k*5 +: 5] = a[4:0];
   endtask

   task automatic set_wr(input int k, input int a, input logic [31:0] d);
      addr_wr[k*5 +: 5]  = a[4:0];
      data_wr[k*32 +: 32] = d;
      we[k] = 1'b1;
   endtask

   function automatic logic [31:0] rd(input int k);
      return data_rd[k*32 +: 32];
   endfunction

   // Counts busy cycles of a pass that is already running; done must stay low throughout.
   task automatic count_pass(input string tag);
      cnt   = 0;
      early = 1'b0;
      while (busy === 1'b1 && cnt < 100) begin
         if (done !== 1'b0) early = 1'b1;
         cnt++;
         step();
      end
      check({tag, "_busy_cycles"}, cnt, 32);
      check({tag, "_no_early_done"}, 32'(early), 0);
      check({tag, "_done"}, 32'(done), 1);
      check({tag, "_ready"}, 32'(ready), 1);
   endtask

   task automatic check_all(input string tag, input logic [31:0] exp);
      for (int b = 0; b < 8; b++) begin
         for (int k = 0; k < 4; k++) set_rd(k, b*4 + k);
         #1;
         for (int k = 0; k < 4; k++) check($sformatf("%s_a%0d", tag, b*4 + k), rd(k), exp);
      end
   endtask

   initial begin
      // Reset held for 3 cycles.
      repeat (3) step();
      check("rst_busy", 32'(busy), 1);
      check("rst_ready", 32'(ready), 0);
      check("rst_done", 32'(done), 0);
      check("rst_conflict", 32'(conf), 0);

      // First pass.
      reset = 1'b1;
      count_pass("init");
      check("init_ready20", 32'(ready20), 1);
      step();
      check("init_done_pulse_ends", 32'(done), 0);
      check_all("init_rd", 32'h0);

      // Same-address writes on ports 0 and 2: port 2 wins, conflict flagged for one cycle.
      set_wr(0, 5, 32'hA);
      set_wr(2, 5, 32'hC);
      set_rd(0, 5);
      #1;
      check("conf_before_edge", 32'(conf), 0);
      step();
      we = '0;
      #1;
      check("conf_flag", 32'(conf), 1);
      check("conf_winner", rd(0), 32'hC);
      step();
      check("conf_clears", 32'(conf), 0);

      // Three distinct addresses in one cycle: no conflict.
      set_wr(0, 1, 32'h11);
      set_wr(1, 2, 32'h22);
      set_wr(2, 3, 32'h33);
      step();
      we = '0;
      set_rd(0, 1); set_rd(1, 2); set_rd(2, 3);
      #1;
      check("multi_no_conf", 32'(conf), 0);
      check("multi_a1", rd(0), 32'h11);
      check("multi_a2", rd(1), 32'h22);
      check("multi_a3", rd(2), 32'h33);

      // Same-cycle read of an address being written.
      set_rd(3, 7);
      set_wr(1, 7, 32'h55);
      #1;
`ifdef SRAM_BYPASS_EN
      check("bypass_same_cycle", rd(3), 32'h55);
`else
      check("no_bypass_same_cycle", rd(3), 32'h0);
`endif
      step();
      we = '0;
      #1;
      check("write_visible_next", rd(3), 32'h55);

      // Non-power-of-two depth: out-of-range writes dropped, no conflict.
      a20_wr = {5'd25, 5'd25};
      d20_wr = {32'hBEEF, 32'hDEAD};
      we20   = 2'b11;
      a20_rd = {5'd19, 5'd25};
      #1;
      check("d20_oor_no_bypass", d20_rd[31:0], 32'h0);
      step();
      we20 = '0;
      #1;
      check("d20_oor_no_conf", 32'(conf20), 0);
      check("d20_oor_read", d20_rd[31:0], 32'h0);
      check("d20_last_entry", d20_rd[63:32], 32'h0);
      a20_wr = {5'd19, 5'd19};
      d20_wr = {32'h88, 32'h77};
      we20   = 2'b11;
      step();
      we20 = '0;
      #1;
      check("d20_conf", 32'(conf20), 1);
      check("d20_winner", d20_rd[63:32], 32'h88);

      // Fill with 0xFF, then clear with a write pair issued mid-pass.
      for (int i = 0; i < 32; i++) begin
         we = '0;
         set_wr(0, i, 32'hFF);
         step();
      end
      we = '0;
      check_all("fill_rd", 32'hFF);
      clear = 1'b1;
      step();
      clear = 1'b0;
      check("clr_busy", 32'(busy), 1);
      check("clr_not_ready", 32'(ready), 0);
      cnt   = 0;
      early = 1'b0;
      while (busy === 1'b1 && cnt < 100) begin
         if (cnt == 10) begin
            set_wr(0, 3, 32'h1234);
            set_wr(1, 3, 32'h5678);
         end
         if (cnt == 11) begin
            we = '0;
            check("clr_write_no_conf", 32'(conf), 0);
         end
         if (done !== 1'b0) early = 1'b1;
         cnt++;
         step();
      end
      we = '0;
      check("clr_busy_cycles", cnt, 32);
      check("clr_no_early_done", 32'(early), 0);
      check("clr_done", 32'(done), 1);
      check_all("clr_rd", 32'h0);

      // Reset at ptr 10 restarts the pass without a done pulse.
      clear = 1'b1;
      step();
      clear = 1'b0;
      early = 1'b0;
      repeat (10) begin
         if (done !== 1'b0) early = 1'b1;
         step();
      end
      check("mid_no_done", 32'(early | done), 0);
      reset = 1'b0;
      #1;
      check("mid_rst_busy", 32'(busy), 1);
      check("mid_rst_done", 32'(done), 0);
      check("mid_rst_ready", 32'(ready), 0);
      step();
      step();
      reset = 1'b1;
      count_pass("restart");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
      $fatal(1, "watchdog expired");
   end

endmodule
